// File: rtl/audio_pkg.sv
// Shared types and widths for the audio record/playback sequencer.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 22;

  typedef enum logic [2:0] {
    StIdle,
    StWrLoad,
    StRecord,
    StDone,
    StRdLoad,
    StPrime,
    StPlay
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge pulse generator.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [1:0] sync_q;
  logic       last_q;

  // Resynchronise d, then keep one more stage to detect the 0->1 edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d};
      last_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~last_q;

endmodule

// File: rtl/audio_rec_play_ctrl.sv
// Audio-side sequencer around the SDRAM FIFO controller: records interleaved L/R words into
// the write FIFO and streams them back from the read FIFO to the DAC.
module audio_rec_play_ctrl
  import audio_pkg::*;
#(
  parameter int                  SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int                  ADDR_W    = audio_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   REC_BASE  = 22'h000000,
  parameter logic [ADDR_W-1:0]   REC_MAX   = 22'h3FFF00,
  parameter int unsigned         LOAD_HOLD = 4,
  parameter int unsigned         PRIME_CYC = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_rec,
  input  logic                key_play,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_l,
  input  logic [SAMPLE_W-1:0] adc_r,
  input  logic                dac_req,
  input  logic                voice_write_done,
  input  logic [SAMPLE_W-1:0] rdf_dout,
  output logic                wr_load,
  output logic                rd_load,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [ADDR_W-1:0]   wr_max_addr,
  output logic [ADDR_W-1:0]   rd_max_addr,
  output logic                wrf_wrreq,
  output logic [SAMPLE_W-1:0] wrf_din,
  output logic                rdf_rdreq,
  output logic [SAMPLE_W-1:0] dac_l,
  output logic [SAMPLE_W-1:0] dac_r,
  output logic                dac_valid,
  output logic                rec_active,
  output logic                play_active,
  output logic                overrun
);

  // Shared counter covers both the load hold and the prime wait.
  localparam int unsigned CNT_MAX = (PRIME_CYC > LOAD_HOLD) ? PRIME_CYC : LOAD_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_load_q, rd_load_q;
  logic                has_rec_q, overrun_q;
  logic                wr_pend_q, done_req_q;
  logic                wrf_wrreq_q;
  logic [SAMPLE_W-1:0] wrf_din_q, r_hold_q;
  logic [1:0]          rd_ph_q;
  logic                rdf_rdreq_q, dac_valid_q;
  logic [SAMPLE_W-1:0] dac_l_q, dac_r_q;
  logic                stop_play_q, stop_rec_q;
  logic                vwd_rise, wr_accept, rd_accept;

  sync_edge u_vwd_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (voice_write_done),
    .rise (vwd_rise)
  );

  // New pairs are accepted only when the previous one is not mid-issue and no exit is pending.
  always_comb begin
    wr_accept = (state_q == StRecord) && adc_valid && !wr_pend_q && !done_req_q;
    rd_accept = (state_q == StPlay) && dac_req && (rd_ph_q == 2'd0) &&
                !stop_play_q && !stop_rec_q;
  end

  // Next-state logic; exits from RECORD/PLAY wait until the in-flight pair has finished.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (key_rec)                    state_d = StWrLoad;
        else if (key_play && has_rec_q) state_d = StRdLoad;
      end
      StWrLoad: begin
        if (cnt_q == CNT_W'(LOAD_HOLD - 1)) state_d = StRecord;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      StRecord: begin
        if ((vwd_rise || done_req_q) && !wr_pend_q && !wr_accept) state_d = StDone;
      end
      StDone: state_d = StIdle;
      StRdLoad: begin
        if (cnt_q == CNT_W'(LOAD_HOLD - 1)) state_d = (PRIME_CYC == 0) ? StPlay : StPrime;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      StPrime: begin
        if (cnt_q == CNT_W'(PRIME_CYC - 1)) state_d = StPlay;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      StPlay: begin
        if ((rd_ph_q == 2'd0) && !rd_accept) begin
          if (key_rec || stop_rec_q)        state_d = StWrLoad;
          else if (key_play || stop_play_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, registered load strobes and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_load_q   <= 1'b0;
      rd_load_q   <= 1'b0;
      has_rec_q   <= 1'b0;
      overrun_q   <= 1'b0;
      done_req_q  <= 1'b0;
      stop_play_q <= 1'b0;
      stop_rec_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // Registered so the strobes crossing to clk_ref are glitch-free.
      wr_load_q <= (state_d == StWrLoad);
      rd_load_q <= (state_d == StRdLoad);
      if (state_q == StWrLoad)   has_rec_q <= 1'b0;
      else if (state_q == StDone) has_rec_q <= 1'b1;
      if ((state_d == StWrLoad) && (state_q != StWrLoad))      overrun_q <= 1'b0;
      else if ((state_q == StRecord) && adc_valid && wr_pend_q) overrun_q <= 1'b1;
      done_req_q  <= (state_q == StRecord) && (done_req_q || vwd_rise);
      stop_play_q <= (state_q == StPlay) && (stop_play_q || key_play);
      stop_rec_q  <= (state_q == StPlay) && (stop_rec_q || key_rec);
    end
  end

  // Write sequencer: L word the cycle after acceptance, R word the cycle after that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrf_wrreq_q <= 1'b0;
      wrf_din_q   <= '0;
      r_hold_q    <= '0;
      wr_pend_q   <= 1'b0;
    end else begin
      wrf_wrreq_q <= 1'b0;
      if (wr_accept) begin
        wrf_wrreq_q <= 1'b1;
        wrf_din_q   <= adc_l;
        r_hold_q    <= adc_r;
        wr_pend_q   <= 1'b1;
      end else if (wr_pend_q) begin
        wrf_wrreq_q <= 1'b1;
        wrf_din_q   <= r_hold_q;
        wr_pend_q   <= 1'b0;
      end
    end
  end

  // Read sequencer: two reads, then capture L and R; dac_valid rises together with the new R.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ph_q     <= 2'd0;
      rdf_rdreq_q <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_l_q     <= '0;
      dac_r_q     <= '0;
    end else begin
      rdf_rdreq_q <= 1'b0;
      dac_valid_q <= 1'b0;
      unique case (rd_ph_q)
        2'd0: begin
          if (rd_accept) begin
            rdf_rdreq_q <= 1'b1;
            rd_ph_q     <= 2'd1;
          end
        end
        2'd1: begin
          rdf_rdreq_q <= 1'b1;
          rd_ph_q     <= 2'd2;
        end
        2'd2: begin
          dac_l_q <= rdf_dout;
          rd_ph_q <= 2'd3;
        end
        default: begin
          dac_r_q     <= rdf_dout;
          dac_valid_q <= 1'b1;
          rd_ph_q     <= 2'd0;
        end
      endcase
    end
  end

  assign wr_addr     = REC_BASE;
  assign rd_addr     = REC_BASE;
  assign wr_max_addr = REC_MAX;
  assign rd_max_addr = REC_MAX;
  assign wr_load     = wr_load_q;
  assign rd_load     = rd_load_q;
  assign wrf_wrreq   = wrf_wrreq_q;
  assign wrf_din     = wrf_din_q;
  assign rdf_rdreq   = rdf_rdreq_q;
  assign dac_l       = dac_l_q;
  assign dac_r       = dac_r_q;
  assign dac_valid   = dac_valid_q;
  assign rec_active  = (state_q == StRecord);
  assign play_active = (state_q == StPlay);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Directed bench for audio_rec_play_ctrl with a simple read-FIFO model returning 1, 2, 3, ...
module tb_audio_rec_play_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_rec = 1'b0;
  logic        key_play = 1'b0;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_l = '0;
  logic [15:0] adc_r = '0;
  logic        dac_req = 1'b0;
  logic        voice_write_done = 1'b0;
  logic [15:0] rdf_dout;
  logic        wr_load, rd_load, wrf_wrreq, rdf_rdreq, dac_valid;
  logic        rec_active, play_active, overrun;
  logic [21:0] wr_addr, rd_addr, wr_max_addr, rd_max_addr;
  logic [15:0] wrf_din, dac_l, dac_r;
  logic [15:0] fifo_ptr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  audio_rec_play_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_rec         (key_rec),
    .key_play        (key_play),
    .adc_valid       (adc_valid),
    .adc_l           (adc_l),
    .adc_r           (adc_r),
    .dac_req         (dac_req),
    .voice_write_done(voice_write_done),
    .rdf_dout        (rdf_dout),
    .wr_load         (wr_load),
    .rd_load         (rd_load),
    .wr_addr         (wr_addr),
    .rd_addr         (rd_addr),
    .wr_max_addr     (wr_max_addr),
    .rd_max_addr     (rd_max_addr),
    .wrf_wrreq       (wrf_wrreq),
    .wrf_din         (wrf_din),
    .rdf_rdreq       (rdf_rdreq),
    .dac_l           (dac_l),
    .dac_r           (dac_r),
    .dac_valid       (dac_valid),
    .rec_active      (rec_active),
    .play_active     (play_active),
    .overrun         (overrun)
  );

  // Read FIFO: data appears the cycle after rdf_rdreq.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_ptr <= '0;
      rdf_dout <= '0;
    end else if (rdf_rdreq) begin
      fifo_ptr <= fifo_ptr + 16'd1;
      rdf_dout <= fifo_ptr + 16'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int cnt, cnt2, rq, lat;
    logic [15:0] vl, vr;
    vl = '0;
    vr = '0;

    // Reset values
    step(); step();
    check("rst_wr_load", 32'(wr_load), 0);
    check("rst_rd_load", 32'(rd_load), 0);
    check("rst_wrreq", 32'(wrf_wrreq), 0);
    check("rst_rdreq", 32'(rdf_rdreq), 0);
    check("rst_dac_valid", 32'(dac_valid), 0);
    check("rst_rec_active", 32'(rec_active), 0);
    check("rst_play_active", 32'(play_active), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("wr_addr", 32'(wr_addr), 32'h0);
    check("rd_addr", 32'(rd_addr), 32'h0);
    check("wr_max_addr", 32'(wr_max_addr), 32'h3FFF00);
    check("rd_max_addr", 32'(rd_max_addr), 32'h3FFF00);
    rst_n = 1'b1;
    step();

    // Play with nothing recorded stays idle
    key_play = 1'b1; step(); key_play = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_load) cnt++;
      if (play_active) cnt2++;
      step();
    end
    check("norec_rd_load", cnt, 0);
    check("norec_play", cnt2, 0);

    // Record: wr_load held 4 cycles, no rd_load overlap
    key_rec = 1'b1; step(); key_rec = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_load) cnt++;
      if (rd_load) cnt2++;
      step();
    end
    check("wr_load_len", cnt, 4);
    check("wr_rd_overlap", cnt2, 0);
    check("rec_active", 32'(rec_active), 1);

    // Keys ignored while recording
    key_rec = 1'b1; step(); key_rec = 1'b0;
    check("rec_key_ignored", 32'(wr_load), 0);
    check("rec_still_active", 32'(rec_active), 1);

    // One pair
    adc_valid = 1'b1; adc_l = 16'h1234; adc_r = 16'hABCD; step();
    adc_valid = 1'b0; adc_l = '0; adc_r = '0;
    check("pair_wrreq_l", 32'(wrf_wrreq), 1);
    check("pair_din_l", 32'(wrf_din), 32'h1234);
    step();
    check("pair_wrreq_r", 32'(wrf_wrreq), 1);
    check("pair_din_r", 32'(wrf_din), 32'hABCD);
    step();
    check("pair_wrreq_end", 32'(wrf_wrreq), 0);
    check("pair_no_overrun", 32'(overrun), 0);

    // Back-to-back adc_valid: second dropped, overrun set
    adc_valid = 1'b1; adc_l = 16'h1111; adc_r = 16'h2222; step();
    check("ovr_din_l", 32'(wrf_din), 32'h1111);
    adc_l = 16'h3333; adc_r = 16'h4444; step();
    adc_valid = 1'b0;
    check("ovr_din_r", 32'(wrf_din), 32'h2222);
    check("ovr_flag", 32'(overrun), 1);
    step();
    check("ovr_wrreq_end", 32'(wrf_wrreq), 0);

    // Region full: DONE three cycles after voice_write_done rises
    voice_write_done = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (rec_active && lat < 10);
    check("vwd_latency", lat, 3);
    voice_write_done = 1'b0;
    step();

    // Play: rd_load 4 cycles, 2048 prime cycles, dac_req ignored during prime
    key_play = 1'b1; step(); key_play = 1'b0;
    cnt = 0; cnt2 = 0; rq = 0;
    for (int i = 0; i < 3000 && !play_active; i++) begin
      if (rd_load) cnt++;
      else cnt2++;
      if (rdf_rdreq || wr_load) rq++;
      dac_req = (i == 200);
      step();
    end
    dac_req = 1'b0;
    check("rd_load_len", cnt, 4);
    check("prime_len", cnt2, 2048);
    check("prime_no_rdreq", rq, 0);
    check("play_active", 32'(play_active), 1);

    // First pair read back
    dac_req = 1'b1; step(); dac_req = 1'b0;
    check("rd_req1", 32'(rdf_rdreq), 1);
    step();
    check("rd_req2", 32'(rdf_rdreq), 1);
    check("rd_valid_early2", 32'(dac_valid), 0);
    step();
    check("rd_req_end", 32'(rdf_rdreq), 0);
    check("rd_dac_l_first", 32'(dac_l), 32'h1);
    check("rd_valid_early3", 32'(dac_valid), 0);
    step();
    check("rd_valid", 32'(dac_valid), 1);
    check("rd_dac_l", 32'(dac_l), 32'h1);
    check("rd_dac_r", 32'(dac_r), 32'h2);
    step();
    check("rd_valid_pulse", 32'(dac_valid), 0);

    // dac_req during a read in flight is dropped
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 8; i++) begin
      dac_req = (i == 0 || i == 2);
      step();
      if (rdf_rdreq) cnt++;
      if (dac_valid) begin
        cnt2++;
        vl = dac_l;
        vr = dac_r;
      end
    end
    dac_req = 1'b0;
    check("drop_rdreq_cnt", cnt, 2);
    check("drop_valid_cnt", cnt2, 1);
    check("drop_dac_l", 32'(vl), 32'h3);
    check("drop_dac_r", 32'(vr), 32'h4);

    // Stop with a request in the same cycle: pair completes, then idle
    key_play = 1'b1; dac_req = 1'b1; step();
    key_play = 1'b0; dac_req = 1'b0;
    cnt = 0; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      if (rdf_rdreq) cnt++;
      if (dac_valid) begin
        lat = i;
        vl = dac_l;
        vr = dac_r;
      end
      dac_req = (i == 6);
      step();
    end
    dac_req = 1'b0;
    check("stop_rdreq_cnt", cnt, 2);
    check("stop_valid_at", lat, 4);
    check("stop_dac_l", 32'(vl), 32'h5);
    check("stop_dac_r", 32'(vr), 32'h6);
    check("stop_play_idle", 32'(play_active), 0);

    // key_rec and key_play together: record wins, overrun cleared
    key_rec = 1'b1; key_play = 1'b1; step();
    key_rec = 1'b0; key_play = 1'b0;
    check("both_wr_load", 32'(wr_load), 1);
    check("both_rd_load", 32'(rd_load), 0);
    check("ovr_cleared", 32'(overrun), 0);
    step(); step(); step(); step();
    check("rec2_active", 32'(rec_active), 1);

    // Asynchronous reset with a write in flight
    adc_valid = 1'b1; adc_l = 16'h5555; adc_r = 16'h6666; step();
    adc_valid = 1'b0;
    check("pre_rst_wrreq", 32'(wrf_wrreq), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wrreq", 32'(wrf_wrreq), 0);
    check("mid_rst_rec", 32'(rec_active), 0);
    check("mid_rst_wr_load", 32'(wr_load), 0);
    step();
    rst_n = 1'b1;
    step();

    // has_rec cleared by reset: play is refused
    key_play = 1'b1; step(); key_play = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_load || play_active) cnt++;
      step();
    end
    check("post_rst_no_play", cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
